// File: rtl/dot_dma_51.sv
// dot_dma_51: memory-initiator engine computing an unsigned dot product of two
// vectors in data memory and writing the result back. Optional DOT_DMA_OVF_EN adds ovf_51.
`timescale 1ns/1ps
module dot_dma_51 #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int CW     = 16,
  parameter int STRIDE = 4
) (
  input  logic          clk_51,
  input  logic          rst_51,
  input  logic          start_51,
  input  logic [AW-1:0] a_base_51,
  input  logic [AW-1:0] b_base_51,
  input  logic [CW-1:0] n_51,
  input  logic [AW-1:0] res_addr_51,
  output logic          busy_51,
  output logic          done_51,
  output logic [DW-1:0] result_51,
  output logic [AW-1:0] mra_51,
  input  logic [DW-1:0] mrd_51,
  output logic [AW-1:0] mwa_51,
  output logic [DW-1:0] mwd_51,
  output logic          mwr_51
`ifdef DOT_DMA_OVF_EN
  ,
  output logic          ovf_51
`endif
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] a_ptr, b_ptr, res;
  logic [CW-1:0] cnt;
  logic [DW-1:0] acc, a_reg, b_reg;
  logic [AW-1:0] mwa_q;
  logic [DW-1:0] mwd_q;
  logic [DW-1:0] acc_nxt;

`ifdef DOT_DMA_OVF_EN
  logic [2*DW-1:0] prod;
  logic [DW:0]     sum;
  logic            ovf_q;

  assign prod    = {{DW{1'b0}}, a_reg} * {{DW{1'b0}}, b_reg};
  assign sum     = {1'b0, acc} + {1'b0, prod[DW-1:0]};
  assign acc_nxt = sum[DW-1:0];
  assign ovf_51  = ovf_q;
`else
  logic [DW-1:0] prod;

  assign prod    = a_reg * b_reg;
  assign acc_nxt = acc + prod;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_51 or negedge rst_51) begin
    if (!rst_51) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_51) state_nxt = (n_51 != '0) ? RD_A : WRITE;
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = MAC;
      MAC:     state_nxt = (cnt == CW'(1)) ? WRITE : RD_A;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write address/data show the live job only in WRITE and hold the last write otherwise.
  always_comb begin
    busy_51 = (state != IDLE);
    done_51 = (state == DONE);
    mwr_51  = (state == WRITE);
    mwa_51  = mwa_q;
    mwd_51  = mwd_q;
    mra_51  = '0;
    unique case (state)
      RD_A:    mra_51 = a_ptr;
      RD_B:    mra_51 = b_ptr;
      WRITE: begin
        mwa_51 = res;
        mwd_51 = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_51 or negedge rst_51) begin
    if (!rst_51) begin
      a_ptr     <= '0;
      b_ptr     <= '0;
      res       <= '0;
      cnt       <= '0;
      acc       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      result_51 <= '0;
      mwa_q     <= '0;
      mwd_q     <= '0;
`ifdef DOT_DMA_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start_51) begin
          a_ptr <= a_base_51;
          b_ptr <= b_base_51;
          cnt   <= n_51;
          res   <= res_addr_51;
          acc   <= '0;
`ifdef DOT_DMA_OVF_EN
          ovf_q <= 1'b0;
`endif
        end
        RD_A: a_reg <= mrd_51;
        RD_B: b_reg <= mrd_51;
        MAC: begin
          acc   <= acc_nxt;
          a_ptr <= a_ptr + AW'(STRIDE);
          b_ptr <= b_ptr + AW'(STRIDE);
          cnt   <= cnt - CW'(1);
`ifdef DOT_DMA_OVF_EN
          if ((prod[2*DW-1:DW] != '0) || sum[DW]) ovf_q <= 1'b1;
`endif
        end
        WRITE: begin
          result_51 <= acc;
          mwa_q     <= res;
          mwd_q     <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule
